// File: rtl/mcast_bus_scheduler_pkg.sv
// Shared types and constants for the multicast bus scheduler.
package mcast_bus_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONFIG = 2'd1,
        ST_RUN    = 2'd2
    } sched_state_t;

    // All-ones tag for a given width; no PE is ever configured with it.
    function automatic logic [63:0] null_tag(input int unsigned width);
        return (64'(1) << width) - 64'(1);
    endfunction

endpackage

// File: rtl/mcast_bus_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    always_comb begin
        int   idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mcast_bus_scheduler.sv
// Configures PE multicast IDs, then schedules requesters onto the shared
// multicast bus with round-robin arbitration.
//   state  | meaning
//   IDLE   | waiting for cfg_start
//   CONFIG | streaming one ID into each PE in order
//   RUN    | arbitrating requesters onto the bus
module mcast_bus_scheduler
    import mcast_bus_scheduler_pkg::*;
#(
    parameter int idBits   = 8,
    parameter int dataSize = 8,
    parameter int numPEs   = 4,
    parameter int numSrc   = 2
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         cfg_start,
    input  logic                         cfg_id_valid,
    input  logic [idBits-1:0]            cfg_id_data,
    output logic                         cfg_id_ready,
    output logic [numPEs-1:0]            pe_id_write,
    output logic [idBits-1:0]            pe_id_data,
    output logic                         cfg_done,
    input  logic                         run_stop,
    input  logic [numSrc-1:0]            src_valid,
    input  logic [numSrc*idBits-1:0]     src_tag,
    input  logic [numSrc*dataSize-1:0]   src_data,
    output logic [numSrc-1:0]            src_ready,
    output logic [idBits-1:0]            cast_tag_o,
    output logic [dataSize-1:0]          cast_data_o,
    output logic                         cast_valid_o,
    output logic                         err_null_tag
);

    localparam int CW = (numPEs > 1) ? $clog2(numPEs) : 1;
    localparam int SPW = (numSrc > 1) ? $clog2(numSrc) : 1;
    localparam logic [idBits-1:0] NULL_TAG = idBits'(null_tag(idBits));

    sched_state_t       state;
    logic [CW-1:0]      pe_cnt;
    logic [SPW-1:0]     rr_ptr;
    logic [numSrc-1:0]  arb_grant;
    logic [SPW-1:0]     g_idx;
    logic [idBits-1:0]  g_tag;
    logic [dataSize-1:0] g_data;
    logic               hs;
    logic               granted;

    rr_arbiter #(.N(numSrc), .PW(SPW)) u_arb (
        .req   (src_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant)
    );

    assign cfg_id_ready = (state == ST_CONFIG);
    assign cfg_done     = (state == ST_RUN);
    assign hs           = cfg_id_valid && cfg_id_ready;
    assign pe_id_data   = cfg_id_data;
    assign src_ready    = (state == ST_RUN) ? arb_grant : '0;
    assign granted      = |src_ready;

    always_comb begin
        pe_id_write = '0;
        if (hs) pe_id_write[pe_cnt] = 1'b1;
    end

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < numSrc; i++) begin
            if (src_ready[i]) g_idx = SPW'(i);
        end
        g_tag  = src_tag[int'(g_idx)*idBits +: idBits];
        g_data = src_data[int'(g_idx)*dataSize +: dataSize];
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= ST_IDLE;
            pe_cnt       <= '0;
            rr_ptr       <= '0;
            cast_tag_o   <= NULL_TAG;
            cast_data_o  <= '0;
            cast_valid_o <= 1'b0;
            err_null_tag <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        state  <= ST_CONFIG;
                        pe_cnt <= '0;
                    end
                end
                ST_CONFIG: begin
                    if (cfg_start) begin
                        pe_cnt <= '0;
                    end else if (run_stop) begin
                        state <= ST_IDLE;
                    end else if (hs) begin
                        if (pe_cnt == CW'(numPEs - 1)) state <= ST_RUN;
                        else pe_cnt <= pe_cnt + CW'(1);
                    end
                end
                ST_RUN: begin
                    if (cfg_start) begin
                        state  <= ST_CONFIG;
                        pe_cnt <= '0;
                    end else if (run_stop) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (cfg_start) err_null_tag <= 1'b0;

            // Bus beat is decided by the grant alone, so a beat granted in the
            // last RUN cycle still goes out after the state has moved on.
            cast_tag_o   <= NULL_TAG;
            cast_data_o  <= '0;
            cast_valid_o <= 1'b0;
            if (granted) begin
                rr_ptr <= (g_idx == SPW'(numSrc - 1)) ? '0 : g_idx + SPW'(1);
                if (g_tag == NULL_TAG) begin
                    err_null_tag <= 1'b1;
                end else begin
                    cast_tag_o   <= g_tag;
                    cast_data_o  <= g_data;
                    cast_valid_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mcast_bus_scheduler.sv
// Directed bench for mcast_bus_scheduler: config, arbitration, null tag, abort, reset.
module tb_mcast_bus_scheduler;

    logic        clk = 1'b0;
    logic        nrst;
    logic        cfg_start, cfg_id_valid, run_stop;
    logic [7:0]  cfg_id_data;
    logic        cfg_id_ready, cfg_done, cast_valid_o, err_null_tag;
    logic [3:0]  pe_id_write;
    logic [7:0]  pe_id_data, cast_tag_o, cast_data_o;
    logic [1:0]  src_valid, src_ready;
    logic [15:0] src_tag, src_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mcast_bus_scheduler #(.idBits(8), .dataSize(8), .numPEs(4), .numSrc(2)) dut (
        .clk(clk), .nrst(nrst), .cfg_start(cfg_start), .cfg_id_valid(cfg_id_valid),
        .cfg_id_data(cfg_id_data), .cfg_id_ready(cfg_id_ready), .pe_id_write(pe_id_write),
        .pe_id_data(pe_id_data), .cfg_done(cfg_done), .run_stop(run_stop),
        .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data), .src_ready(src_ready),
        .cast_tag_o(cast_tag_o), .cast_data_o(cast_data_o), .cast_valid_o(cast_valid_o),
        .err_null_tag(err_null_tag)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0;
    endtask

    initial begin
        logic [7:0] ids [4];
        logic [7:0] fair_tag [2];
        ids = '{8'd3, 8'd5, 8'd7, 8'd9};
        fair_tag = '{8'd3, 8'd5};

        nrst = 1'b0; cfg_start = 0; cfg_id_valid = 0; run_stop = 0;
        cfg_id_data = 0; src_valid = 2'b11; src_tag = 0; src_data = 0;
        #12;
        check_eq("rst_ready",    cfg_id_ready, 0);
        check_eq("rst_pe_write", pe_id_write, 0);
        check_eq("rst_done",     cfg_done, 0);
        check_eq("rst_src_rdy",  src_ready, 0);
        check_eq("rst_tag",      cast_tag_o, 8'hFF);
        check_eq("rst_valid",    cast_valid_o, 0);
        check_eq("rst_err",      err_null_tag, 0);

        @(negedge clk); nrst = 1'b1;
        @(negedge clk); #1;
        check_eq("idle_src_rdy", src_ready, 0);
        check_eq("idle_ready",   cfg_id_ready, 0);

        // Configuration with valid held high
        cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0; cfg_id_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cfg_id_data = ids[i];
            #1;
            check_eq("cfg_ready",    cfg_id_ready, 1);
            check_eq("cfg_pe_write", pe_id_write, 4'b0001 << i);
            check_eq("cfg_pe_data",  pe_id_data, ids[i]);
            check_eq("cfg_done_lo",  cfg_done, 0);
            check_eq("cfg_src_rdy",  src_ready, 0);
            @(negedge clk);
        end
        cfg_id_valid = 1'b0; src_valid = 2'b00;
        #1;
        check_eq("cfg_done_hi",   cfg_done, 1);
        check_eq("run_ready_lo",  cfg_id_ready, 0);
        check_eq("run_pe_write",  pe_id_write, 0);

        @(negedge clk); #1;
        check_eq("idle_bus_tag",   cast_tag_o, 8'hFF);
        check_eq("idle_bus_valid", cast_valid_o, 0);
        check_eq("idle_bus_data",  cast_data_o, 0);

        // Fairness: both sources valid for 4 cycles
        src_valid = 2'b11; src_tag = {8'd5, 8'd3}; src_data = {8'hB1, 8'hA0};
        #1;
        for (int k = 0; k < 4; k++) begin
            check_eq("rr_grant", src_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) begin
                check_eq("rr_bus_tag",   cast_tag_o, fair_tag[(k - 1) % 2]);
                check_eq("rr_bus_valid", cast_valid_o, 1);
            end
            @(negedge clk); #1;
        end
        src_valid = 2'b00;
        #1;
        check_eq("rr_last_tag",  cast_tag_o, 8'd5);
        check_eq("rr_last_data", cast_data_o, 8'hB1);
        check_eq("rr_last_vld",  cast_valid_o, 1);
        @(negedge clk); #1;
        check_eq("rr_after_vld", cast_valid_o, 0);
        check_eq("rr_after_tag", cast_tag_o, 8'hFF);

        // Null tag on source 0
        src_valid = 2'b01; src_tag = {8'd5, 8'hFF};
        #1;
        check_eq("null_grant", src_ready, 2'b01);
        @(negedge clk); src_valid = 2'b00; #1;
        check_eq("null_no_beat", cast_valid_o, 0);
        check_eq("null_bus_tag", cast_tag_o, 8'hFF);
        check_eq("null_err",     err_null_tag, 1);
        @(negedge clk); #1;
        check_eq("null_err_hold", err_null_tag, 1);

        // Abort after 2 of 4 IDs, then restart at PE 0
        pulse_start(); #1;
        check_eq("restart_err_clr", err_null_tag, 0);
        check_eq("restart_ready",   cfg_id_ready, 1);
        cfg_id_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cfg_id_data = 8'd11 + 8'(i); #1;
            check_eq("abort_pe_write", pe_id_write, 4'b0001 << i);
            @(negedge clk);
        end
        cfg_id_valid = 1'b0; run_stop = 1'b1;
        @(negedge clk); run_stop = 1'b0; #1;
        check_eq("abort_ready", cfg_id_ready, 0);
        check_eq("abort_done",  cfg_done, 0);
        pulse_start();
        cfg_id_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cfg_id_data = 8'd21 + 8'(i); #1;
            check_eq("recfg_pe_write", pe_id_write, 4'b0001 << i);
            @(negedge clk);
        end
        cfg_id_valid = 1'b0; #1;
        check_eq("recfg_done", cfg_done, 1);

        // Reset with a beat in flight; rr_ptr is 1 from the null-tag grant
        src_valid = 2'b10; src_tag = {8'd5, 8'd3}; src_data = {8'hC4, 8'h00};
        #1;
        check_eq("flight_grant", src_ready, 2'b10);
        @(posedge clk); #1;
        check_eq("flight_valid", cast_valid_o, 1);
        check_eq("flight_tag",   cast_tag_o, 8'd5);
        nrst = 1'b0; #1;
        check_eq("arst_valid",   cast_valid_o, 0);
        check_eq("arst_tag",     cast_tag_o, 8'hFF);
        check_eq("arst_data",    cast_data_o, 0);
        check_eq("arst_done",    cfg_done, 0);
        check_eq("arst_src_rdy", src_ready, 0);
        @(negedge clk); nrst = 1'b1;
        @(negedge clk); #1;
        check_eq("post_rst_valid", cast_valid_o, 0);
        check_eq("post_rst_rdy",   src_ready, 0);
        @(negedge clk); #1;
        check_eq("post_rst_valid2", cast_valid_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcast_bus_scheduler.md
MCAST_BUS_SCHEDULER -- requirements
Module: mcast_bus_scheduler

Interface
REQ-001 SHALL have parameters: idBits, default 8, tag/ID width; dataSize, default 8, bus data width; numPEs, default 4, number of PE multicast controllers; numSrc, default 2, number of bus requesters.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk, input, 1, clock.
- nrst, input, 1, reset, asynchronous, active-low.
- cfg_start, input, 1, pulse that starts the ID configuration phase.
- cfg_id_valid, input, 1, ID stream valid.
- cfg_id_data, input, idBits, ID for the next PE.
- cfg_id_ready, output, 1, ID stream ready.
- pe_id_write, output, numPEs, one-hot ID write strobes to the PEs.
- pe_id_data, output, idBits, ID write data to the PEs.
- cfg_done, output, 1, high while in RUN.
- run_stop, input, 1, return to IDLE.
- src_valid, input, numSrc, per-requester valid.
- src_tag, input, numSrc*idBits, packed tags; requester i occupies [i*idBits +: idBits].
- src_data, input, numSrc*dataSize, packed data.
- src_ready, output, numSrc, one-hot grant.
- cast_tag_o, output, idBits, multicast bus tag.
- cast_data_o, output, dataSize, multicast bus data.
- cast_valid_o, output, 1, bus beat valid.
- err_null_tag, output, 1, sticky flag: a request carried the null tag.

Function
REQ-003 SHALL implement the FSM states IDLE, CONFIG and RUN.
REQ-004 SHALL move IDLE->CONFIG on cfg_start, and RUN->CONFIG on cfg_start; entering CONFIG clears the PE counter.
REQ-005 In CONFIG, SHALL assert cfg_id_ready.
REQ-006 In CONFIG, on each cfg_id_valid&cfg_id_ready handshake, SHALL drive pe_id_write one-hot at the PE counter index and pe_id_data=cfg_id_data in that same cycle (combinational), then increment the counter.
REQ-007 SHALL transition CONFIG->RUN on the handshake for PE numPEs-1; the counter SHALL NOT wrap, and cfg_id_ready SHALL be 0 outside CONFIG.
REQ-008 pe_id_write SHALL be all-zero whenever no handshake occurs.
REQ-009 SHALL assert cfg_done only in RUN.
REQ-010 In RUN, run_stop SHALL return the FSM to IDLE; in CONFIG, run_stop SHALL abort to IDLE.
REQ-011 If cfg_start and run_stop are both high, cfg_start SHALL win.
REQ-012 In RUN, SHALL grant the lowest index at or after rr_ptr with src_valid set; src_ready SHALL be that grant (one-hot, combinational from src_valid and rr_ptr), and all-zero outside RUN.
REQ-013 On a grant to index g, SHALL update rr_ptr to (g+1) mod numSrc.
REQ-014 A granted beat SHALL appear on cast_tag_o/cast_data_o with cast_valid_o=1 exactly one cycle after the handshake, for one cycle.
REQ-015 With no beat, SHALL drive cast_tag_o=NULL_TAG (all ones), cast_data_o=0 and cast_valid_o=0, so that no PE ID matches the bus.
REQ-016 A granted request with tag==NULL_TAG SHALL be consumed, SHALL NOT be emitted, and SHALL set err_null_tag; err_null_tag clears only on reset or cfg_start.
REQ-017 A beat registered in the cycle of a state change SHALL still be emitted in the next cycle.

Reset
REQ-018 On nrst low, SHALL set: state=IDLE, PE counter=0, rr_ptr=0, cast_tag_o=NULL_TAG, cast_data_o=0, cast_valid_o=0, err_null_tag=0; pe_id_write=0, cfg_id_ready=0, src_ready=0, cfg_done=0.
REQ-019 Reset mid-CONFIG or mid-RUN SHALL discard all progress; PEs retain their previously written IDs.

Structure
REQ-020 A shared package SHALL hold the state enum (IDLE/CONFIG/RUN) and the NULL_TAG constant function of idBits.
REQ-021 The round-robin grant logic SHALL be a sub-module rr_arbiter (inputs: req, ptr; output: one-hot grant).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Config: numPEs=4; cfg_start, then IDs 3,5,7,9 with valid always high -> pe_id_write 0001,0010,0100,1000 on consecutive cycles; cfg_done rises the cycle after the 4th handshake.
- Fairness: in RUN, both sources valid for 4 cycles, tags 3 and 5 -> grants 0,1,0,1; bus tags 3,5,3,5, each lagging its grant by 1 cycle.
- Idle bus: no src_valid -> cast_tag_o=0xFF, cast_valid_o=0; src_ready=00 in IDLE/CONFIG even with src_valid=11.
- Null tag: src0 tag 0xFF -> src_ready[0]=1, no bus beat, err_null_tag=1 until the next cfg_start.
- Abort: run_stop after 2 of 4 IDs -> IDLE, cfg_id_ready=0; a new cfg_start restarts at PE 0.
- Reset: nrst asserted mid-RUN with a beat in flight -> outputs take reset values asynchronously; no beat appears after release.
